// File: rtl/fpu_pkg.sv
// Shared types, constants and the result packer for the sequential single-precision subtractor.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 24;
  localparam int RES_W  = 25;
  localparam int DIFF_W = 5;

  localparam logic [DIFF_W-1:0] DIFF_SAT = 5'd25;
  localparam logic [31:0]       QNAN     = 32'h7FC00000;
  localparam logic [EXP_W-1:0]  EXP_MAX  = 8'hFF;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  typedef struct packed {
    logic zero;
    logic denorm;
    logic normal;
    logic inf;
    logic nan;
  } fclass_t;

  // A mantissa that never regained its hidden bit can only sit at exp 1, so it encodes as exp 0.
  function automatic logic [31:0] fp_pack(input logic s, input logic [EXP_W-1:0] e,
                                          input logic [MANT_W-1:0] m);
    logic [31:0] r;
    if (m == '0)             r = 32'h0000_0000;
    else if (e == EXP_MAX)   r = {s, EXP_MAX, 23'd0};
    else if (!m[MANT_W-1])   r = {s, 8'h00, m[22:0]};
    else                     r = {s, e, m[22:0]};
    return r;
  endfunction

endpackage

// File: rtl/fpu_special_detect.sv
// Combinational classifier of an IEEE-754 single magnitude (sign is handled by the caller).
module fpu_special_detect
  import fpu_pkg::*;
(
  input  logic [30:0] mag_i,
  output fclass_t     cls_o
);

  logic exp_zero;
  logic exp_max;
  logic frac_zero;

  assign exp_zero  = (mag_i[30:23] == 8'h00);
  assign exp_max   = (mag_i[30:23] == EXP_MAX);
  assign frac_zero = (mag_i[22:0] == 23'd0);

  always_comb begin
    cls_o.zero   = exp_zero & frac_zero;
    cls_o.denorm = exp_zero & ~frac_zero;
    cls_o.normal = ~exp_zero & ~exp_max;
    cls_o.inf    = exp_max & frac_zero;
    cls_o.nan    = exp_max & ~frac_zero;
  end

endmodule

// File: rtl/fpu_subtractor_seq.sv
// Multi-cycle single-precision a - b: bit-serial alignment, one add cycle, bit-serial normalisation.
// Truncating rounding; one operation in flight, result held in DONE until out_ready.
module fpu_subtractor_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out
);

  state_t              state_q, state_d;
  logic                sx_q, sx_d, sy_q, sy_d, rs_q, rs_d;
  logic [EXP_W-1:0]    ex_q, ex_d, ey_q, ey_d, er_q, er_d;
  logic [MANT_W-1:0]   mx_q, mx_d, my_q, my_d;
  logic [RES_W-1:0]    mr_q, mr_d;
  logic [DIFF_W-1:0]   diff_q, diff_d;
  logic                ord_q, ord_d, spec_q, spec_d;
  logic [31:0]         out_q, out_d;

  fclass_t             ca, cb;
  logic [EXP_W-1:0]    ea, eb, ediff;
  logic                spec_hit;
  logic [31:0]         spec_res;

  fpu_special_detect u_det_a (.mag_i(a[30:0]), .cls_o(ca));
  fpu_special_detect u_det_b (.mag_i(b[30:0]), .cls_o(cb));

  assign ea = (ca.zero | ca.denorm) ? 8'd1 : a[30:23];
  assign eb = (cb.zero | cb.denorm) ? 8'd1 : b[30:23];

  // Subtrahend sign is flipped, so two infinities of equal stored sign cancel into NaN.
  assign spec_hit = ca.nan | cb.nan | ca.inf | cb.inf;
  assign spec_res = (ca.nan | cb.nan | (ca.inf & cb.inf & (a[31] == b[31]))) ? QNAN :
                    ca.inf ? {a[31], EXP_MAX, 23'd0} : {~b[31], EXP_MAX, 23'd0};

  assign ediff = (ex_q >= ey_q) ? ex_q - ey_q : ey_q - ex_q;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;

  always_comb begin
    state_d = state_q;
    sx_d = sx_q;  sy_d = sy_q;  rs_d = rs_q;
    ex_d = ex_q;  ey_d = ey_q;  er_d = er_q;
    mx_d = mx_q;  my_d = my_q;  mr_d = mr_q;
    diff_d = diff_q;  ord_d = ord_q;  spec_d = spec_q;  out_d = out_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sx_d = a[31];   ex_d = ea;  mx_d = {ca.normal, a[22:0]};
        sy_d = ~b[31];  ey_d = eb;  my_d = {cb.normal, b[22:0]};
        spec_d = spec_hit;
        out_d  = spec_res;
        ord_d  = 1'b0;
        state_d = ALIGN;
      end
      ALIGN: begin
        if (spec_q) begin
          state_d = DONE;
        end else if (!ord_q) begin
          // First cycle orders the operands so x always carries the larger exponent.
          if (ex_q < ey_q) begin
            sx_d = sy_q;  ex_d = ey_q;  mx_d = my_q;
            sy_d = sx_q;  ey_d = ex_q;  my_d = mx_q;
          end
          diff_d = (ediff > {3'b000, DIFF_SAT}) ? DIFF_SAT : ediff[DIFF_W-1:0];
          ord_d  = 1'b1;
        end else if (diff_q != '0) begin
          my_d   = my_q >> 1;
          diff_d = diff_q - 1'b1;
        end else begin
          state_d = ADD;
        end
      end
      ADD: begin
        er_d = ex_q;
        if (sx_q == sy_q) begin
          mr_d = {1'b0, mx_q} + {1'b0, my_q};
          rs_d = sx_q;
        end else if (mx_q >= my_q) begin
          mr_d = {1'b0, mx_q} - {1'b0, my_q};
          rs_d = sx_q;
        end else begin
          mr_d = {1'b0, my_q} - {1'b0, mx_q};
          rs_d = sy_q;
        end
        state_d = NORM;
      end
      NORM: begin
        if (mr_q[RES_W-1]) begin
          out_d   = fp_pack(rs_q, er_q + 8'd1, mr_q[RES_W-1:1]);
          state_d = DONE;
        end else if (!mr_q[MANT_W-1] && (er_q > 8'd1) && (mr_q != '0)) begin
          mr_d = {mr_q[RES_W-2:0], 1'b0};
          er_d = er_q - 8'd1;
        end else begin
          out_d   = fp_pack(rs_q, er_q, mr_q[MANT_W-1:0]);
          state_d = DONE;
        end
      end
      DONE: if (out_ready) begin
        out_d   = 32'h0000_0000;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sx_q <= 1'b0;  sy_q <= 1'b0;  rs_q <= 1'b0;
      ex_q <= '0;    ey_q <= '0;    er_q <= '0;
      mx_q <= '0;    my_q <= '0;    mr_q <= '0;
      diff_q <= '0;  ord_q <= 1'b0; spec_q <= 1'b0;
      out_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      sx_q <= sx_d;  sy_q <= sy_d;  rs_q <= rs_d;
      ex_q <= ex_d;  ey_q <= ey_d;  er_q <= er_d;
      mx_q <= mx_d;  my_q <= my_d;  mr_q <= mr_d;
      diff_q <= diff_d;  ord_q <= ord_d;  spec_q <= spec_d;
      out_q <= out_d;
    end
  end

endmodule

// File: doc/fpu_subtractor_seq.md
FPU_SUBTRACTOR_SEQ -- requirements
Module: fpu_subtractor_seq

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: in_valid  in  1  operands a/b present.
REQ-004 SHALL have ports: in_ready  out  1  block accepts operands (high only in IDLE).
REQ-005 SHALL have ports: a  in  32  IEEE-754 single minuend.
REQ-006 SHALL have ports: b  in  32  IEEE-754 single subtrahend.
REQ-007 SHALL have ports: out_valid  out  1  result available.
REQ-008 SHALL have ports: out_ready  in  1  consumer takes result.
REQ-009 SHALL have ports: out  out  32  IEEE-754 single result a - b.
REQ-010 SHALL have no parameters; width fixed at 32.

Function
REQ-011 SHALL compute a - b as a + b' where b' = {~b[31], b[30:0]}.
REQ-012 SHALL accept operands on the rising edge where in_valid && in_ready; a/b SHALL be registered, and later changes to a/b are ignored.
REQ-013 SHALL use FSM states IDLE, ALIGN, ADD, NORM, DONE; accept moves IDLE->ALIGN.
REQ-014 Unpack on accept: exp 0 -> exp 1 with hidden bit 0; else hidden bit 1; 24-bit mantissa, 25-bit result mantissa.
REQ-015 ALIGN: each cycle with diff != 0, the smaller-exponent mantissa SHALL shift right 1 bit, with diff decremented; diff == 0 -> ADD; diff SHALL saturate at 25 (mantissa becomes 0).
REQ-016 ADD (1 cycle): same effective sign -> mantissa sum; opposite -> larger magnitude minus smaller; sign = sign of larger magnitude; equal magnitudes -> result +0.
REQ-017 NORM: if bit24 set, SHALL right-shift 1 and increment exp in one cycle; else, while bit23 == 0, exp > 1 and mantissa != 0, SHALL left-shift 1 and decrement exp per cycle; otherwise -> DONE.
REQ-018 If NORM ends with bit23 == 0, exp SHALL encode as 0 (denormal); a zero mantissa SHALL give 0x00000000.
REQ-019 Rounding SHALL be truncation; shifted-out bits are discarded.
REQ-020 Exp reaching 255 after normalization SHALL give a signed infinity (mantissa 0).
REQ-021 Specials are resolved at accept and go straight to DONE on the next edge: either NaN -> 0x7FC00000; inf - inf of equal sign -> 0x7FC00000; otherwise an infinite operand gives the correctly signed infinity.
REQ-022 Latency, normal path: out_valid SHALL rise (diff + 4 + left-shift count) cycles after the accept edge.
REQ-023 DONE: out_valid = 1 and out SHALL be held stable until out_ready is sampled high; then -> IDLE on that edge.
REQ-024 in_ready = 1 only in IDLE; accept in the same cycle as a DONE handshake SHALL NOT occur.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, in_ready = 1, out_valid = 0, out = 0x00000000, and clear all datapath registers, including mid-ALIGN/NORM.
REQ-026 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Structure
REQ-027 Shared package fpu_pkg SHALL hold the state enum, QNAN = 32'h7FC00000, EXP_MAX = 8'hFF, and the mantissa/exponent width constants.
REQ-028 A single combinational sub-module fpu_special_detect SHALL classify each operand (zero, denormal, normal, inf, NaN); all other logic is inline.

Verification
REQ-029 a=0x40400000 (3.0), b=0x3F800000 (1.0) -> out=0x40000000; out_valid rises 5 cycles after accept.
REQ-030 a=0x3F800000, b=0x3F400000 (1.0-0.75) -> out=0x3E800000 after 2 NORM left-shifts; latency 7.
REQ-031 a=0x3FC00000, b=0xBFC00000 (1.5-(-1.5)) -> out=0x40400000 via bit24 right-shift; latency 4.
REQ-032 a=b=0x3F800000 -> out=0x00000000; a=0x7F800000, b=0x7F800000 -> 0x7FC00000; a=0x7FC00001 -> 0x7FC00000.
REQ-033 Hold out_ready=0 for 10 cycles in DONE -> out and out_valid stable, in_ready=0; then a 1-cycle out_ready -> IDLE, in_ready=1 next cycle.
REQ-034 Pulse rst_n low during NORM of the REQ-030 case -> out_valid=0, out=0 immediately; a fresh operation then completes correctly.
